// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the execute-stage divider.
//   div_state_e     - divider FSM states
//   DIV_ITERS       - restoring iterations per full-width divide
//   CNT_W           - width of the iteration counter
//   DIV_ZERO_RESULT - {HI,LO} value loaded for divide-by-zero / zero dividend
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } div_state_e;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [63:0] DIV_ZERO_RESULT = 64'h0;

endpackage

// File: rtl/clz32.sv
// clz32: combinational leading-zero counter.
// Ports:
//   a_i     - 32-bit input word
//   count_o - number of leading zeros, 0..32 (32 when a_i == 0)
module clz32 (
  input  logic [31:0] a_i,
  output logic [5:0]  count_o
);

  // Scanning upward lets the highest set bit be the last (winning) assignment.
  always_comb begin
    count_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a_i[i]) begin
        count_o = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV / DIVU in the E stage.
// Works on operand magnitudes, then applies sign correction on entry to DONE.
// Ports:
//   clk, rst   - pipeline clock, synchronous active-high reset
//   start_i    - DIV/DIVU present in E (held while it sits there)
//   signed_i   - 1 = DIV (two's complement), 0 = DIVU
//   a_i, b_i   - dividend / divisor, sampled only when an operation starts
//   annul_i    - E-stage flush; abandons the current operation
//   stall_o    - stall_divE to the hazard unit (combinational)
//   ready_o    - result valid this cycle
//   result_o   - {HI = remainder, LO = quotient}, held until the next load
// Build option: define DIV_EARLY_OUT_EN to skip leading-zero dividend bits
// (BUSY lasts 32 - clz(|a|) cycles). Results are identical either way.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic                annul_i,
  output logic                stall_o,
  output logic                ready_o,
  output logic [2*DATA_W-1:0] result_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DIV_ITERS - 1);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic                sgn_q, sgn_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  // Operand magnitudes (raw for DIVU).
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic                b_zero;

  assign a_neg  = signed_i & a_i[DATA_W-1];
  assign b_neg  = signed_i & b_i[DATA_W-1];
  assign abs_a  = a_neg ? -a_i : a_i;
  assign abs_b  = b_neg ? -b_i : b_i;
  assign b_zero = (b_i == '0);

  // Start-up values for the iteration, with or without early-out.
  logic [DATA_W-1:0]   dvd_init;
  logic [CNT_W-1:0]    cnt_init;
  logic                skip_busy;

`ifdef DIV_EARLY_OUT_EN
  logic [5:0] lz;

  clz32 u_clz32 (
    .a_i     (abs_a),
    .count_o (lz)
  );

  // Leading zero bits would only produce zero quotient bits; pre-shift them out.
  assign dvd_init  = abs_a << lz[4:0];
  assign cnt_init  = lz[4:0];
  assign skip_busy = b_zero | lz[5];
`else
  assign dvd_init  = abs_a;
  assign cnt_init  = '0;
  assign skip_busy = b_zero;
`endif

  // One restoring step. The shifted remainder needs DATA_W+1 bits: with an
  // unsigned divisor above 2^(DATA_W-1) the partial remainder can exceed it.
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     rem_diff;
  logic                q_bit;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign rem_sh   = {rem_q, dvd_q[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, dsr_q};
  assign q_bit    = (rem_sh >= {1'b0, dsr_q});
  assign rem_next = q_bit ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign quo_next = {dvd_q[DATA_W-2:0], q_bit};

  // Wrap-around negation: MIN / -1 yields MIN with zero remainder.
  assign quo_fix = (sgn_q && (sa_q ^ sb_q)) ? -quo_next : quo_next;
  assign rem_fix = (sgn_q && sa_q) ? -rem_next : rem_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;

    if (annul_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sgn_d = signed_i;
            sa_d  = a_neg;
            sb_d  = b_neg;
            dsr_d = abs_b;
            dvd_d = dvd_init;
            rem_d = '0;
            cnt_d = cnt_init;
            if (skip_busy) begin
              state_d  = StDone;
              result_d = (2*DATA_W)'(DIV_ZERO_RESULT);
            end else begin
              state_d = StBusy;
            end
          end
        end
        StBusy: begin
          rem_d = rem_next;
          dvd_d = quo_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) begin
            state_d  = StDone;
            result_d = {rem_fix, quo_fix};
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sgn_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      sgn_q    <= sgn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  // Combinational so the stall is already up in the cycle the divide enters E.
  assign stall_o  = start_i & ~annul_i & (state_q != StDone);
  assign ready_o  = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Build option: DIV_EARLY_OUT_EN (expected stall lengths follow it).
module tb_div_unit;
  import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        annul_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_unit #(
    .DATA_W (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected number of stall cycles (also the cycle index at which ready_o rises).
  function automatic int model_stall(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int          n;
    if (b == 32'd0) return 1;
    if (!EarlyOut) return 33;
    m = (sg && a[31]) ? -a : a;
    if (m == 32'd0) return 1;
    n = 0;
    while (!m[31]) begin
      m = m << 1;
      n++;
    end
    return 33 - n;
  endfunction

  // Issue one divide at posedge+1, follow it to ready_o, check timing and result.
  task automatic do_op(input string tag, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res, input bit keep_start);
    int          stalls = 0;
    int          rdy_at = -1;
    int          exp_n;
    logic [63:0] res_at_rdy = '1;
    exp_n    = model_stall(sg, a, b);
    signed_i = sg;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
    for (int c = 0; c < 40 && rdy_at < 0; c++) begin
      #1;
      if (stall_o) stalls++;
      if (ready_o) begin
        rdy_at     = c;
        res_at_rdy = result_o;
      end
      @(posedge clk);
      #1;
      // Operands after capture must not matter.
      if (c == 0) begin
        a_i = ~a;
        b_i = b ^ 32'h5;
      end
    end
    if (!keep_start) start_i = 1'b0;
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_n));
    check({tag, "_ready_cycle"}, 64'(rdy_at), 64'(exp_n));
    check({tag, "_result"}, res_at_rdy, exp_res);
    #1;
    check({tag, "_ready_one_cycle"}, 64'(ready_o), 64'd0);
    check({tag, "_result_held"}, result_o, exp_res);
  endtask

  initial begin
    int annul_at;
    int seen;

    rst      = 1'b1;
    start_i  = 1'b0;
    signed_i = 1'b0;
    a_i      = '0;
    b_i      = '0;
    annul_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_stall", 64'(stall_o), 64'd0);
    check("reset_state", 64'(dut.state_q), 64'(StIdle));
    check("reset_cnt", 64'(dut.cnt_q), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
    do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0);
    do_op("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 1'b0);
    do_op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'd1, 32'd1}, 1'b0);
    do_op("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 1'b0);
    do_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 1'b0);
    do_op("div_0_5", 1'b1, 32'd0, 32'd5, 64'd0, 1'b0);
    do_op("divu_3_1", 1'b0, 32'd3, 32'd1, {32'd0, 32'd3}, 1'b0);

    // Annul mid-operation: no result load, no ready.
    annul_at = EarlyOut ? 3 : 10;
    signed_i = 1'b0;
    a_i      = 32'd100;
    b_i      = 32'd7;
    start_i  = 1'b1;
    repeat (annul_at) @(posedge clk);
    #1;
    check("annul_busy_before", 64'(dut.state_q), 64'(StBusy));
    annul_i = 1'b1;
    #1;
    check("annul_stall_low", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul_state_idle", 64'(dut.state_q), 64'(StIdle));
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready_o) seen++;
      @(posedge clk);
      #1;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    check("annul_result_kept", result_o, {32'd0, 32'd3});

    do_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    // Back-to-back with start_i held high throughout.
    do_op("b2b_first", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    do_op("b2b_second", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0);

    // Annul together with start in IDLE: nothing starts.
    @(posedge clk);
    #1;
    signed_i = 1'b0;
    a_i      = 32'd9;
    b_i      = 32'd0;
    start_i  = 1'b1;
    annul_i  = 1'b1;
    #1;
    check("annul_start_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    check("annul_start_idle", 64'(dut.state_q), 64'(StIdle));
    check("annul_start_ready", 64'(ready_o), 64'd0);
    check("annul_start_result", result_o, {32'd0, 32'd10});

    // Reset in the middle of an operation.
    a_i     = 32'd100;
    b_i     = 32'd7;
    start_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    start_i = 1'b0;
    check("midrst_state", 64'(dut.state_q), 64'(StIdle));
    check("midrst_result", result_o, 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_cnt", 64'(dut.cnt_q), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
